// File: rtl/accelerator_calculus_pkg.sv
// Shared definitions for the calculus accelerator blocks: fixed-point format,
// saturation limits and the common control-state encoding.
package accelerator_calculus_pkg;

    localparam int DEFAULT_DATA_SIZE = 64;
    localparam int FRACTION_SIZE     = 32;

    localparam logic signed [DEFAULT_DATA_SIZE-1:0] ONE      = 64'sd1 <<< FRACTION_SIZE;
    localparam logic signed [DEFAULT_DATA_SIZE-1:0] MAX_DATA = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [DEFAULT_DATA_SIZE-1:0] MIN_DATA = 64'sh8000_0000_0000_0000;

    typedef enum logic [1:0] {
        STARTER_STATE = 2'd0,
        INPUT_STATE   = 2'd1,
        ENDER_STATE   = 2'd2
    } state_t;

endpackage

// File: rtl/accelerator_scalar_fixed_multiplier.sv
// Combinational signed fixed-point multiply: (DATA_SIZE+1)-bit operand times
// DATA_SIZE-bit operand, fraction bits dropped (floor), saturated to DATA_SIZE.
module accelerator_scalar_fixed_multiplier #(
    parameter int DATA_SIZE     = 64,
    parameter int FRACTION_SIZE = 32
) (
    input  logic signed [DATA_SIZE:0]   factor_a,
    input  logic signed [DATA_SIZE-1:0] factor_b,
    output logic        [DATA_SIZE-1:0] result,
    output logic                        overflow
);

    localparam int WIDE = 2 * DATA_SIZE + 1;

    // Output range limits, sign-extended to the full product width.
    localparam logic signed [WIDE-1:0] MAX_WIDE = {{(DATA_SIZE + 2){1'b0}}, {(DATA_SIZE - 1){1'b1}}};
    localparam logic signed [WIDE-1:0] MIN_WIDE = {{(DATA_SIZE + 2){1'b1}}, {(DATA_SIZE - 1){1'b0}}};

    logic signed [WIDE-1:0] product;
    logic signed [WIDE-1:0] shifted;

    always_comb begin
        product  = WIDE'(factor_a) * WIDE'(factor_b);
        shifted  = product >>> FRACTION_SIZE;
        result   = shifted[DATA_SIZE-1:0];
        overflow = 1'b0;
        if (shifted > MAX_WIDE) begin
            result   = MAX_WIDE[DATA_SIZE-1:0];
            overflow = 1'b1;
        end else if (shifted < MIN_WIDE) begin
            result   = MIN_WIDE[DATA_SIZE-1:0];
            overflow = 1'b1;
        end
    end

endmodule

// File: rtl/accelerator_vector_differentiation.sv
// Streaming finite-difference differentiator: out[i] = (x[i] - x[i-1]) * (1/h),
// out[0] = 0, one registered result per accepted sample.
module accelerator_vector_differentiation #(
    parameter int DATA_SIZE     = 64,
    parameter int CONTROL_SIZE  = 4,
    parameter int FRACTION_SIZE = accelerator_calculus_pkg::FRACTION_SIZE
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,
    input  logic [DATA_SIZE-1:0]    LENGTH_IN,
    input  logic                    DATA_IN_ENABLE,
    output logic                    DATA_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    output logic                    DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    OVERFLOW
);
    import accelerator_calculus_pkg::*;

    state_t                  state_reg;
    logic [CONTROL_SIZE-1:0] count_reg;
    logic [CONTROL_SIZE-1:0] size_reg;
    logic [DATA_SIZE-1:0]    length_reg;
    logic [DATA_SIZE-1:0]    prev_reg;

    logic signed [DATA_SIZE:0] diff;
    logic [DATA_SIZE-1:0]      product;
    logic                      product_overflow;
    logic                      accept;
    logic                      first;
    logic                      last;

    // One extra bit so the difference of two extreme samples cannot wrap.
    assign diff   = {DATA_IN[DATA_SIZE-1], DATA_IN} - {prev_reg[DATA_SIZE-1], prev_reg};
    assign accept = (state_reg == INPUT_STATE) && DATA_IN_ENABLE;
    assign first  = (count_reg == '0);
    assign last   = (count_reg == size_reg - CONTROL_SIZE'(1));

    accelerator_scalar_fixed_multiplier #(
        .DATA_SIZE     (DATA_SIZE),
        .FRACTION_SIZE (FRACTION_SIZE)
    ) u_multiplier (
        .factor_a (diff),
        .factor_b (length_reg),
        .result   (product),
        .overflow (product_overflow)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg       <= STARTER_STATE;
            count_reg       <= '0;
            size_reg        <= '0;
            length_reg      <= '0;
            prev_reg        <= '0;
            READY           <= 1'b0;
            DATA_ENABLE     <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
            DATA_OUT        <= '0;
            OVERFLOW        <= 1'b0;
        end else begin
            READY           <= 1'b0;
            DATA_OUT_ENABLE <= 1'b0;
            case (state_reg)
                // ENDER is the READY cycle; a START here is taken like one from idle.
                STARTER_STATE, ENDER_STATE: begin
                    state_reg <= STARTER_STATE;
                    if (START) begin
                        size_reg   <= SIZE_IN;
                        length_reg <= LENGTH_IN;
                        count_reg  <= '0;
                        OVERFLOW   <= 1'b0;
                        if (SIZE_IN == '0) begin
                            READY <= 1'b1;
                        end else begin
                            state_reg   <= INPUT_STATE;
                            DATA_ENABLE <= 1'b1;
                        end
                    end
                end
                INPUT_STATE: begin
                    if (accept) begin
                        DATA_OUT_ENABLE <= 1'b1;
                        prev_reg        <= DATA_IN;
                        count_reg       <= count_reg + CONTROL_SIZE'(1);
                        if (first) begin
                            DATA_OUT <= '0;
                        end else begin
                            DATA_OUT <= product;
                            if (product_overflow) begin
                                OVERFLOW <= 1'b1;
                            end
                        end
                        if (last) begin
                            DATA_ENABLE <= 1'b0;
                            READY       <= 1'b1;
                            state_reg   <= ENDER_STATE;
                        end
                    end
                end
                default: state_reg <= STARTER_STATE;
            endcase
        end
    end

endmodule

// File: tb/tb_accelerator_vector_differentiation.sv
// Self-checking bench: directed and random vectors compared against a
// fixed-point finite-difference reference model.
module tb_accelerator_vector_differentiation;
    import accelerator_calculus_pkg::*;

    localparam int DW   = DEFAULT_DATA_SIZE;
    localparam int CW   = 4;
    localparam int WIDE = 2 * DW + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          ready;
    logic [CW-1:0] size_in;
    logic [DW-1:0] length_in;
    logic          data_in_enable;
    logic          data_enable;
    logic [DW-1:0] data_in;
    logic          data_out_enable;
    logic [DW-1:0] data_out;
    logic          overflow;

    always #5 clk = ~clk;

    accelerator_vector_differentiation #(
        .DATA_SIZE     (DW),
        .CONTROL_SIZE  (CW),
        .FRACTION_SIZE (FRACTION_SIZE)
    ) dut (
        .CLK             (clk),
        .RST             (rst_n),
        .START           (start),
        .READY           (ready),
        .SIZE_IN         (size_in),
        .LENGTH_IN       (length_in),
        .DATA_IN_ENABLE  (data_in_enable),
        .DATA_ENABLE     (data_enable),
        .DATA_IN         (data_in),
        .DATA_OUT_ENABLE (data_out_enable),
        .DATA_OUT        (data_out),
        .OVERFLOW        (overflow)
    );

    int            check_count = 0;
    int            pass_count  = 0;
    logic [DW-1:0] vec [16];
    logic          model_ovf = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        check_count++;
        if (got === want) pass_count++;
        else $display("FAIL %s: got %h, expected %h", tag, got, want);
    endtask

    // Exact difference times 1/h, fraction bits dropped toward -inf, clamped.
    function automatic logic [DW-1:0] model_deriv(input logic [DW-1:0] cur, input logic [DW-1:0] prev,
                                                  input logic [DW-1:0] len, output logic sat);
        logic signed [WIDE-1:0] delta;
        logic signed [WIDE-1:0] scaled;
        delta  = WIDE'($signed(cur)) - WIDE'($signed(prev));
        scaled = (delta * WIDE'($signed(len))) >>> FRACTION_SIZE;
        sat    = 1'b1;
        if (scaled > WIDE'(MAX_DATA)) return MAX_DATA;
        if (scaled < WIDE'(MIN_DATA)) return MIN_DATA;
        sat = 1'b0;
        return scaled[DW-1:0];
    endfunction

    // Call at a falling edge; returns at the falling edge where READY is high.
    task automatic run_vector(input int size, input logic [DW-1:0] len, input int gap, input bit junk);
        logic [DW-1:0] want;
        logic          sat;
        $display("vector: size=%0d length=%h gap=%0d junk=%0d", size, len, gap, junk);
        start     = 1'b1;
        size_in   = CW'(size);
        length_in = len;
        @(negedge clk);
        start     = 1'b0;
        size_in   = CW'($urandom);
        length_in = {$urandom, $urandom};
        model_ovf = 1'b0;
        check("overflow_clear", DW'(overflow), '0);
        if (size == 0) begin
            check("empty_ready", DW'(ready), DW'(1));
            check("empty_enable", DW'(data_enable), '0);
            check("empty_out_en", DW'(data_out_enable), '0);
            @(negedge clk);
            check("empty_ready_pulse", DW'(ready), '0);
            check("empty_no_out", DW'(data_out_enable), '0);
            return;
        end
        check("enable_high", DW'(data_enable), DW'(1));
        want = '0;
        for (int i = 0; i < size; i++) begin
            data_in        = vec[i];
            data_in_enable = 1'b1;
            if (junk && i == 1) begin
                start   = 1'b1;
                size_in = '0;
            end
            @(negedge clk);
            data_in_enable = 1'b0;
            start          = 1'b0;
            data_in        = {$urandom, $urandom};
            if (i == 0) begin
                want = '0;
            end else begin
                want      = model_deriv(vec[i], vec[i-1], len, sat);
                model_ovf = model_ovf | sat;
            end
            check("out_en", DW'(data_out_enable), DW'(1));
            check($sformatf("out[%0d]", i), data_out, want);
            check("ready", DW'(ready), DW'(i == size - 1));
            check("data_enable", DW'(data_enable), DW'(i != size - 1));
            check("overflow", DW'(overflow), DW'(model_ovf));
            if (i != size - 1) begin
                repeat (gap) begin
                    @(negedge clk);
                    check("gap_out_en", DW'(data_out_enable), '0);
                    check("gap_hold", data_out, want);
                end
            end
        end
    endtask

    // Strobes and noise while idle must not produce anything.
    task automatic idle_junk(input int cycles);
        $display("idle: %0d cycles with stray DATA_IN_ENABLE", cycles);
        repeat (cycles) begin
            data_in_enable = 1'b1;
            data_in        = {$urandom, $urandom};
            @(negedge clk);
            check("idle_out_en", DW'(data_out_enable), '0);
            check("idle_enable", DW'(data_enable), '0);
            check("idle_ready", DW'(ready), '0);
            check("idle_overflow", DW'(overflow), DW'(model_ovf));
        end
        data_in_enable = 1'b0;
    endtask

    initial begin
        int            size;
        logic [DW-1:0] len;
        logic [31:0]   r;

        rst_n          = 1'b0;
        start          = 1'b0;
        size_in        = '0;
        length_in      = '0;
        data_in_enable = 1'b0;
        data_in        = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", DW'(ready), '0);
        check("reset_enable", DW'(data_enable), '0);
        check("reset_out_en", DW'(data_out_enable), '0);
        check("reset_out", data_out, '0);
        check("reset_overflow", DW'(overflow), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic, scaled, scaled with gaps; each START lands on the previous READY cycle.
        for (int i = 0; i < 4; i++) vec[i] = DW'(i * i) << FRACTION_SIZE;
        run_vector(4, ONE, 0, 1'b0);
        run_vector(4, ONE <<< 1, 0, 1'b0);
        run_vector(4, ONE <<< 1, 3, 1'b0);
        @(negedge clk);
        idle_junk(3);

        // Saturation, then sticky flag while idle.
        vec[0] = MIN_DATA;
        vec[1] = MAX_DATA;
        run_vector(2, ONE, 0, 1'b0);
        check("sat_value", data_out, MAX_DATA);
        check("sat_flag", DW'(overflow), DW'(1));
        @(negedge clk);
        idle_junk(3);

        run_vector(0, ONE, 0, 1'b0);

        // Maximum size with a stray START mid-vector.
        for (int i = 0; i < 15; i++) vec[i] = DW'(i) << FRACTION_SIZE;
        run_vector(15, ONE, 0, 1'b1);
        @(negedge clk);
        idle_junk(2);

        repeat (20) begin
            size = $urandom_range(1, 15);
            for (int i = 0; i < size; i++) begin
                r = $urandom;
                vec[i] = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom} : {{32{r[31]}}, r};
            end
            len = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : DW'($urandom_range(1, 8)) << FRACTION_SIZE;
            run_vector(size, len, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                idle_junk(1);
            end
        end
        @(negedge clk);

        // Asynchronous reset in the middle of a vector.
        $display("reset: abort after 2 of 4 samples");
        for (int i = 0; i < 4; i++) vec[i] = DW'(i * i) << FRACTION_SIZE;
        start     = 1'b1;
        size_in   = CW'(4);
        length_in = ONE;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in        = vec[i];
            data_in_enable = 1'b1;
            @(negedge clk);
            data_in_enable = 1'b0;
        end
        check("pre_reset_out", data_out, ONE);
        #2 rst_n = 1'b0;
        #1;
        check("async_ready", DW'(ready), '0);
        check("async_enable", DW'(data_enable), '0);
        check("async_out_en", DW'(data_out_enable), '0);
        check("async_out", data_out, '0);
        check("async_overflow", DW'(overflow), '0);
        @(negedge clk);
        rst_n     = 1'b1;
        model_ovf = 1'b0;
        @(negedge clk);
        idle_junk(2);
        vec[0] = DW'(3) << FRACTION_SIZE;
        vec[1] = DW'(5) << FRACTION_SIZE;
        run_vector(2, ONE, 0, 1'b0);
        check("post_reset_out", data_out, ONE <<< 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/accelerator_vector_differentiation.md
Name: accelerator_vector_differentiation

Overview:
- Streaming finite-difference differentiator for the calculus accelerator. Implements the vector-differentiation function exercised by the calculus stimulus set.
- Consumes a vector of SIZE_IN signed fixed-point samples, one per DATA_IN_ENABLE strobe.
- Emits one derivative sample per input: out[i] = (x[i] - x[i-1]) * LENGTH_IN, with out[0] = 0. LENGTH_IN carries 1/h, the reciprocal sample step.
- Sits between the vector stimulus/memory feeder and the downstream integration or compare stage.

Parameters:
- DATA_SIZE, 64, sample width in bits; signed two's complement.
- CONTROL_SIZE, 4, width of the SIZE_IN element counter.
- FRACTION_SIZE, 32, fractional bits of the fixed-point format, i.e. Q(DATA_SIZE-FRACTION_SIZE).FRACTION_SIZE.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse that begins an operation.
- READY  out  1  one-cycle pulse when the last result is emitted.
- SIZE_IN  in  CONTROL_SIZE  number of vector elements.
- LENGTH_IN  in  DATA_SIZE  reciprocal step 1/h, fixed point.
- DATA_IN_ENABLE  in  1  input sample valid.
- DATA_ENABLE  out  1  block is accepting samples.
- DATA_IN  in  DATA_SIZE  input sample.
- DATA_OUT_ENABLE  out  1  output sample valid.
- DATA_OUT  out  DATA_SIZE  derivative sample.
- OVERFLOW  out  1  sticky saturation flag.

Behaviour:
- Reset: while RST=0, asynchronously force state to STARTER_STATE and clear every output (READY, DATA_ENABLE, DATA_OUT_ENABLE, DATA_OUT, OVERFLOW), the counter, the previous-sample register and the latched operands. Reset mid-operation abandons the vector; no partial READY is produced.
- STARTER_STATE:
  - DATA_ENABLE=0.
  - On START, latch SIZE_IN and LENGTH_IN, clear OVERFLOW and the counter.
  - If SIZE_IN=0: pulse READY on the next cycle and stay idle; no outputs.
  - Otherwise go to INPUT_STATE.
- INPUT_STATE:
  - DATA_ENABLE=1.
  - Each cycle with DATA_IN_ENABLE=1 accepts one sample. Back-to-back strobes on every cycle are legal. Cycles without a strobe stall with no effect.
  - Element 0: result = 0; store x[0] as the previous sample.
  - Element i>0: d = x[i] - prev, computed at DATA_SIZE+1 bits; p = d * LENGTH, signed full width. The result is p[DATA_SIZE+FRACTION_SIZE-1:FRACTION_SIZE], saturated to the DATA_SIZE signed range. If saturation occurs, set OVERFLOW=1; it stays set until the next accepted START.
  - Update prev = x[i]; increment the counter.
- Output timing:
  - Latency is 1 cycle: DATA_OUT and DATA_OUT_ENABLE are registered and assert the cycle after the accepted strobe.
  - DATA_OUT_ENABLE is a one-cycle pulse.
  - DATA_OUT holds its last value between pulses.
- Completion:
  - When element SIZE-1 is accepted, drop DATA_ENABLE next cycle and go to ENDER_STATE.
  - READY pulses in the same cycle as the last DATA_OUT_ENABLE, then the block returns to STARTER_STATE.
- Ignored events:
  - START while not in STARTER_STATE.
  - DATA_IN_ENABLE while DATA_ENABLE=0.
  - Changes to SIZE_IN or LENGTH_IN after latching.
- Counter: compares against the latched SIZE. The maximum size 2^CONTROL_SIZE-1 must complete without wrap.
- A START arriving on the same cycle as READY is accepted; a new operation may begin immediately.

Decomposition:
- Shared package accelerator_calculus_pkg adds:
  - FRACTION_SIZE.
  - A state enum typedef (STARTER_STATE, INPUT_STATE, ENDER_STATE) of width 2.
  - Fixed-point constants ONE = 1<<FRACTION_SIZE, MAX_DATA and MIN_DATA.
- One sub-module: accelerator_scalar_fixed_multiplier. It is combinational: signed (DATA_SIZE+1) x DATA_SIZE multiply with fraction shift and saturation, outputs result and overflow. It is reused later by the integration block.

Test Plan (fixed-point values below use FRACTION_SIZE=32; ONE = 0x1_0000_0000):
- Basic difference: SIZE=4, LENGTH=ONE, x = 0, 1.0, 4.0, 9.0 on back-to-back cycles -> out = 0, 1.0, 3.0, 5.0. Each output is 1 cycle after its input; READY coincides with the 4th DATA_OUT_ENABLE; OVERFLOW=0.
- Scaling: same x, LENGTH = 2.0 (0x2_0000_0000) -> out = 0, 2.0, 6.0, 10.0. Then repeat with gaps of 3 idle cycles between strobes -> identical values, each 1 cycle after its strobe.
- Saturation: SIZE=2, LENGTH=ONE, x0 = 0x8000_0000_0000_0000, x1 = 0x7FFF_FFFF_FFFF_FFFF -> out1 = 0x7FFF_FFFF_FFFF_FFFF and OVERFLOW=1. OVERFLOW stays 1 until the next START, which clears it.
- Empty and maximum size:
  - SIZE=0 -> READY exactly 1 cycle after START; no DATA_OUT_ENABLE.
  - SIZE=15 with x[i]=i*ONE -> 15 outputs: 0 then 1.0 each; no wrap.
- Ignored inputs: START and DATA_IN_ENABLE asserted mid-vector; DATA_IN_ENABLE asserted while idle -> no state change and no extra outputs. START on the READY cycle starts a new vector correctly.
- Reset mid-operation: drop RST after 2 of 4 samples -> all outputs are 0 immediately (asynchronous). After release the block is idle, and a fresh SIZE=2 vector 3.0, 5.0 gives out = 0, 2.0.
